// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the HI/LO multiply/divide unit.
// Signed multiply uses 32 radix-2 Booth steps. Signed divide uses 32 restoring
// steps on magnitudes and then one sign fix-up cycle. HI/LO keep the previous
// result until the transition into DONE.
// Optional feature macro: MULDIV_FAST_ZERO_EN makes a multiply with a zero
// operand skip the Booth steps and complete in one cycle with HI=LO=0.
module muldiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MULT = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Magnitude of a two's complement word. 0x80000000 maps to 2^31, which is
  // still exact when the result is read as unsigned.
  function automatic logic [31:0] f_abs(input logic signed [31:0] v);
    logic [31:0] r;
    r = v[31] ? (~v + 32'd1) : v;
    return r;
  endfunction

  // Conditional two's complement negation used by the divide sign fix-up.
  function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    r = neg ? (~v + 32'd1) : v;
    return r;
  endfunction

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  // Booth working registers. The accumulator carries one guard bit so that
  // subtracting a multiplicand of -2^31 does not overflow.
  logic signed [32:0] r_acc;
  logic [31:0]        r_q;
  logic               r_qm1;
  logic signed [32:0] r_mcand;

  // Restoring-divide working registers (unsigned magnitudes plus sign bits).
  logic [31:0]        r_rem;
  logic [31:0]        r_quo;
  logic [31:0]        r_dvs;
  logic               r_sign_q;
  logic               r_sign_r;

  logic signed [33:0] w_acc_ext;
  logic signed [33:0] w_mcand_ext;
  logic signed [33:0] w_booth_sum;
  logic [32:0]        w_rem_sh;
  logic               w_fits;
  logic [31:0]        w_trial;
  logic [31:0]        w_rem_nxt;
  logic [31:0]        w_quo_nxt;
  logic               w_fast_zero;

  assign w_acc_ext   = {r_acc[32], r_acc};
  assign w_mcand_ext = {r_mcand[32], r_mcand};

  // Booth add/subtract selected by the current multiplier bit pair.
  always_comb begin
    w_booth_sum = w_acc_ext;
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = w_acc_ext + w_mcand_ext;
      2'b10:   w_booth_sum = w_acc_ext - w_mcand_ext;
      default: w_booth_sum = w_acc_ext;
    endcase
  end

  // One restoring-divide step: shift in the next dividend bit and keep the
  // trial difference only when it does not borrow. When it fits, the true
  // difference is below the divisor, so its low 32 bits are exact.
  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_fits    = (w_rem_sh >= {1'b0, r_dvs});
  assign w_trial   = w_rem_sh[31:0] - r_dvs;
  assign w_rem_nxt = w_fits ? w_trial : w_rem_sh[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fits};

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fast_zero = (a == 32'd0) || (b == 32'd0);
`else
  assign w_fast_zero = 1'b0;
`endif

  // Control FSM with registered busy/done/div_zero and the HI/LO result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_acc      <= '0;
      r_q        <= 32'd0;
      r_qm1      <= 1'b0;
      r_mcand    <= '0;
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_dvs      <= 32'd0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
          if (start) begin
            r_cnt    <= 5'd0;
            r_acc    <= '0;
            r_q      <= a;
            r_qm1    <= 1'b0;
            r_mcand  <= {b[31], b};
            r_rem    <= 32'd0;
            r_quo    <= f_abs(a);
            r_dvs    <= f_abs(b);
            r_sign_q <= a[31] ^ b[31];
            r_sign_r <= a[31];
            if (op) begin
              if (b == 32'd0) begin
                // Divide by zero: report immediately, HI/LO untouched.
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_div_zero <= 1'b1;
              end else begin
                r_state <= S_DIV;
                r_busy  <= 1'b1;
              end
            end else if (w_fast_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_hi    <= 32'd0;
              r_lo    <= 32'd0;
            end else begin
              r_state <= S_MULT;
              r_busy  <= 1'b1;
            end
          end
        end

        S_MULT: begin
          // Add/subtract then arithmetic shift of {acc, q, q-1} right by one.
          r_acc <= w_booth_sum[33:1];
          r_q   <= {w_booth_sum[0], r_q[31:1]};
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_booth_sum[32:1];
            r_lo    <= {w_booth_sum[0], r_q[31:1]};
          end
        end

        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // Quotient takes sign(a)^sign(b); remainder takes sign(a).
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_lo    <= f_neg_if(r_quo, r_sign_q);
          r_hi    <= f_neg_if(r_rem, r_sign_r);
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: a latency/arithmetic reference model checked every
// cycle, plus directed operations with hand-computed results.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

`ifdef MULDIV_FAST_ZERO_EN
  localparam bit FZ = 1'b1;
`else
  localparam bit FZ = 1'b0;
`endif

  // Reference model: outputs expected in the cycle after each edge.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
  int          m_left = 0;

  always @(posedge clock) begin
    longint sa, sb, pr, qt, rm;
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      m_dz = 1'b0;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
      end else begin
        m_busy = 1'b1; m_done = 1'b0;
      end
    end else begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      if (start) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
          pr = sa * sb;
          p_hi = pr[63:32]; p_lo = pr[31:0];
          if (FZ && (a == 32'd0 || b == 32'd0)) begin
            m_done = 1'b1; m_hi = 32'd0; m_lo = 32'd0;
          end else begin
            m_left = 32; m_busy = 1'b1;
          end
        end else if (b == 32'd0) begin
          m_done = 1'b1; m_dz = 1'b1;
        end else begin
          qt = sa / sb;
          rm = sa % sb;
          p_lo = qt[31:0]; p_hi = rm[31:0];
          m_left = 33; m_busy = 1'b1;
        end
      end
    end
    #1;
    vectors++;
    if ({busy, done, div_zero, hi, lo} !== {m_busy, m_done, m_dz, m_hi, m_lo}) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h want busy=%b done=%b dz=%b hi=%h lo=%h",
               $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
    end
  end

  // Issue one operation from the current negedge and wait for done.
  task automatic run_op(input logic t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz,
                        input int e_lat, input string name);
    int cyc;
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(negedge clock);
    start = 1'b0; op = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clock);
      cyc++;
    end
    vectors++;
    if (cyc != e_lat) begin
      miscompares++;
      $display("FAIL %s_latency got %0d want %0d", name, cyc, e_lat);
    end
    vectors++;
    if ({hi, lo, div_zero} !== {e_hi, e_lo, e_dz}) begin
      miscompares++;
      $display("FAIL %s_result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
               name, hi, lo, div_zero, e_hi, e_lo, e_dz);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 20));
      4:       v = -32'($urandom_range(1, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    bit seen_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    vectors++;
    if ({busy, done, div_zero, hi, lo} !== {3'b000, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
               busy, done, div_zero, hi, lo);
    end

    // Consecutive calls start in the DONE cycle, exercising back-to-back issue.
    run_op(1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, "mul_7_m3");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, "mul_min_min");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, "div_m7_2");
    run_op(1'b1, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1,  "div_by_zero");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, "div_overflow");
    run_op(1'b0, 32'd0,         32'h1234,      32'd0,         32'd0,         1'b0, FZ ? 1 : 33, "mul_zero");
    run_op(1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34, "div_100_7");

    // Start 5x6, re-pulse start at edge 10, reset at edge 20.
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_ignored got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++;
    if ({busy, done, hi, lo} !== {2'b00, 64'd0}) begin
      miscompares++;
      $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL no_done_after_reset got done seen want none");
    end
    run_op(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, "mul_5_6");

    // Randomized traffic checked by the per-cycle model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 1'($urandom_range(0, 1));
      a     = pick_operand();
      b     = pick_operand();
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clock);
    end
    start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
